// File: rtl/npu_fc2_argmax.sv
// Argmax over one FC2 logit frame, result held on a valid/ack handshake with a sticky frame error.
// Optional runner-up tracking is compiled in when ARGMAX_TOP2_EN is defined.
`ifndef FC2_LAYER_ENC
`define FC2_LAYER_ENC 3'd4
`endif

module npu_fc2_argmax #(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_CLASSES     = 24,
    parameter int CLASS_IDX_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [2:0]                        npu_layer_in_progress,
    input  logic signed [DATA_WIDTH-1:0]      fc2_data,
    input  logic                              fc2_valid_p,
    input  logic                              result_ack,
    output logic                              result_valid,
    output logic [CLASS_IDX_WIDTH-1:0]        result_class,
    output logic signed [DATA_WIDTH-1:0]      result_score,
    output logic [CLASS_IDX_WIDTH-1:0]        result_class2,
    output logic signed [DATA_WIDTH-1:0]      result_score2,
    output logic                              busy,
    output logic                              frame_err
);
    localparam logic [2:0] FC2_ENC = `FC2_LAYER_ENC;
    localparam int CNT_W = CLASS_IDX_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    function automatic logic greater(input logic signed [DATA_WIDTH-1:0] a,
                                     input logic signed [DATA_WIDTH-1:0] b);
        return a > b;
    endfunction

    state_t                        state;
    logic [2:0]                    layer_r;
    logic [CNT_W-1:0]              cnt;
    logic signed [DATA_WIDTH-1:0]  best;
    logic [CLASS_IDX_WIDTH-1:0]    best_idx;
    logic [CLASS_IDX_WIDTH-1:0]    idx;
    logic                          is_fc2;
    logic                          frame_start;
    logic                          last_smp;
    logic                          accept;

    assign idx         = cnt[CLASS_IDX_WIDTH-1:0];
    assign is_fc2      = (npu_layer_in_progress == FC2_ENC);
    assign frame_start = is_fc2 && (layer_r != FC2_ENC);
    assign last_smp    = fc2_valid_p && (cnt == LAST);
    // An ack in the same cycle as a new frame start releases the old result and accepts the frame.
    assign accept      = frame_start && ((state == IDLE) || ((state == DONE) && result_ack));

`ifdef ARGMAX_TOP2_EN
    logic signed [DATA_WIDTH-1:0]  sec;
    logic [CLASS_IDX_WIDTH-1:0]    sec_idx;
    logic                          sec_set;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            layer_r      <= '0;
            cnt          <= '0;
            best         <= '0;
            best_idx     <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
`ifdef ARGMAX_TOP2_EN
            sec          <= '0;
            sec_idx      <= '0;
            sec_set      <= 1'b0;
`endif
        end else begin
            layer_r <= npu_layer_in_progress;
            if (accept) begin
                state        <= COLLECT;
                busy         <= 1'b1;
                result_valid <= 1'b0;
                cnt          <= '0;
                best         <= '0;
                best_idx     <= '0;
                frame_err    <= 1'b0;
`ifdef ARGMAX_TOP2_EN
                sec          <= '0;
                sec_idx      <= '0;
                sec_set      <= 1'b0;
`endif
            end else begin
                case (state)
                    COLLECT: begin
                        // The final strobe wins over a simultaneous layer change.
                        if (!is_fc2 && !last_smp) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                        end else if (fc2_valid_p) begin
                            cnt <= cnt + 1'b1;
                            if ((cnt == '0) || greater(fc2_data, best)) begin
                                best     <= fc2_data;
                                best_idx <= idx;
                            end
`ifdef ARGMAX_TOP2_EN
                            if (cnt == '0) begin
                                sec_set <= 1'b0;
                            end else if (greater(fc2_data, best)) begin
                                sec     <= best;
                                sec_idx <= best_idx;
                                sec_set <= 1'b1;
                            end else if (!sec_set || greater(fc2_data, sec)) begin
                                sec     <= fc2_data;
                                sec_idx <= idx;
                                sec_set <= 1'b1;
                            end
`endif
                            if (cnt == LAST) begin
                                state        <= DONE;
                                busy         <= 1'b0;
                                result_valid <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (result_ack) begin
                            state        <= IDLE;
                            result_valid <= 1'b0;
                        end
                        if (fc2_valid_p || frame_start) begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign result_class = best_idx;
    assign result_score = best;
`ifdef ARGMAX_TOP2_EN
    assign result_class2 = sec_idx;
    assign result_score2 = sec;
`else
    assign result_class2 = '0;
    assign result_score2 = '0;
`endif

endmodule

// File: tb/tb_npu_fc2_argmax.sv
// Directed bench for npu_fc2_argmax: argmax, tie rule, abort, overrun, extra sample, async reset.
`ifndef FC2_LAYER_ENC
`define FC2_LAYER_ENC 3'd4
`endif

module tb_npu_fc2_argmax;
    localparam logic [2:0] FC2 = `FC2_LAYER_ENC;
    localparam logic [2:0] OTHER = FC2 ^ 3'd1;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        npu_layer_in_progress;
    logic signed [7:0] fc2_data;
    logic              fc2_valid_p;
    logic              result_ack;
    logic              result_valid;
    logic [4:0]        result_class;
    logic signed [7:0] result_score;
    logic [4:0]        result_class2;
    logic signed [7:0] result_score2;
    logic              busy;
    logic              frame_err;

    logic signed [7:0] logits [0:31];
    int n_chk = 0;
    int n_pass = 0;

    npu_fc2_argmax #(.DATA_WIDTH(8), .NUM_CLASSES(24), .CLASS_IDX_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .npu_layer_in_progress(npu_layer_in_progress),
        .fc2_data(fc2_data), .fc2_valid_p(fc2_valid_p), .result_ack(result_ack),
        .result_valid(result_valid), .result_class(result_class), .result_score(result_score),
        .result_class2(result_class2), .result_score2(result_score2),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_strobes(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            fc2_data    = logits[i];
            fc2_valid_p = 1'b1;
            step();
        end
        fc2_valid_p = 1'b0;
    endtask

    task automatic run_frame(input int n);
        npu_layer_in_progress = FC2;
        step();
        send_strobes(0, n);
    endtask

    task automatic ack_result();
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        npu_layer_in_progress = OTHER;
        step();
    endtask

    initial begin
        rst = 1'b0;
        npu_layer_in_progress = OTHER;
        fc2_data = '0;
        fc2_valid_p = 1'b0;
        result_ack = 1'b0;
        #12;
        check("rst_valid", int'(result_valid), 0);
        check("rst_class", int'(result_class), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(frame_err), 0);
        rst = 1'b1;
        step();
        step();

        // Ramp -10..13
        for (int i = 0; i < 24; i++) logits[i] = 8'(i - 10);
        npu_layer_in_progress = FC2;
        step();
        send_strobes(0, 23);
        check("ramp_busy_pre", int'(busy), 1);
        check("ramp_valid_pre", int'(result_valid), 0);
        send_strobes(23, 1);
        check("ramp_valid", int'(result_valid), 1);
        check("ramp_class", int'(result_class), 23);
        check("ramp_score", int'(result_score), 13);
        check("ramp_busy", int'(busy), 0);
        check("ramp_err", int'(frame_err), 0);
        ack_result();
        check("ack_valid", int'(result_valid), 0);

        // All equal: lowest index wins
        for (int i = 0; i < 24; i++) logits[i] = 8'sd5;
        run_frame(24);
        check("tie_class", int'(result_class), 0);
        check("tie_score", int'(result_score), 5);
        ack_result();

        // Most negative values
        for (int i = 0; i < 24; i++) logits[i] = -8'sd128;
        logits[7] = -8'sd127;
        run_frame(24);
        check("neg_class", int'(result_class), 7);
        check("neg_score", int'(result_score), -127);
        ack_result();

        // Layer leaves FC2 after 20 strobes
        for (int i = 0; i < 24; i++) logits[i] = 8'(3 * i);
        run_frame(20);
        npu_layer_in_progress = OTHER;
        step();
        check("abort_err", int'(frame_err), 1);
        check("abort_valid", int'(result_valid), 0);
        check("abort_busy", int'(busy), 0);
        step();
        check("abort_valid_late", int'(result_valid), 0);

        // Two peaks; also clears the sticky error
        for (int i = 0; i < 24; i++) logits[i] = 8'sd0;
        logits[3] = 8'sd40;
        logits[9] = 8'sd60;
        run_frame(24);
        check("top_class", int'(result_class), 9);
        check("top_score", int'(result_score), 60);
        check("top_err_clr", int'(frame_err), 0);
`ifdef ARGMAX_TOP2_EN
        check("top_class2", int'(result_class2), 3);
        check("top_score2", int'(result_score2), 40);
`else
        check("top_class2", int'(result_class2), 0);
        check("top_score2", int'(result_score2), 0);
`endif

        // Overrun: new frame start while result unacknowledged
        npu_layer_in_progress = OTHER;
        step();
        npu_layer_in_progress = FC2;
        step();
        check("ovr_err", int'(frame_err), 1);
        check("ovr_valid", int'(result_valid), 1);
        check("ovr_class", int'(result_class), 9);
        check("ovr_score", int'(result_score), 60);
        check("ovr_busy", int'(busy), 0);

        // Ack together with frame start accepts the new frame
        npu_layer_in_progress = OTHER;
        step();
        npu_layer_in_progress = FC2;
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        check("ackst_busy", int'(busy), 1);
        check("ackst_valid", int'(result_valid), 0);
        check("ackst_err", int'(frame_err), 0);
        for (int i = 0; i < 24; i++) logits[i] = 8'(i - 10);
        send_strobes(0, 24);
        check("ackst_class", int'(result_class), 23);
        check("ackst_score", int'(result_score), 13);

        // 25th strobe while result held
        logits[24] = 8'sd100;
        send_strobes(24, 1);
        check("extra_err", int'(frame_err), 1);
        check("extra_class", int'(result_class), 23);
        check("extra_score", int'(result_score), 13);
        check("extra_valid", int'(result_valid), 1);
        ack_result();

        // Async reset mid-collect
        run_frame(10);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_class", int'(result_class), 0);
        check("mid_rst_score", int'(result_score), 0);
        npu_layer_in_progress = OTHER;
        step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 24; i++) logits[i] = -8'sd128;
        logits[7] = -8'sd127;
        run_frame(24);
        check("post_rst_valid", int'(result_valid), 1);
        check("post_rst_class", int'(result_class), 7);
        check("post_rst_score", int'(result_score), -127);
        ack_result();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
